// File: rtl/bsg_mem_1rw_sync_mask_write_var_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_mem_1rw_sync_mask_write_var_ctrl_if
//  Purpose  : Two-requester request/response bundle for the masked-write
//             memory front end. Each field carries one slice per requester.
//  Revision : 1.0 - initial release
// ============================================================================
interface bsg_mem_1rw_sync_mask_write_var_ctrl_if #(
    parameter int width_p      = 32,
    parameter int addr_width_p = 3
);
    // Request side
    logic [1:0]                   v_i;
    logic [1:0]                   w_i;
    logic [1:0][addr_width_p-1:0] addr_i;
    logic [1:0][width_p-1:0]      data_i;
    logic [1:0][width_p-1:0]      w_mask_i;
    logic [1:0]                   yumi_o;

    // Response side
    logic [1:0]                   v_o;
    logic [1:0][width_p-1:0]      data_o;
    logic [1:0]                   yumi_i;

    // Requesters drive requests and consume responses
    modport master (
        output v_i, w_i, addr_i, data_i, w_mask_i, yumi_i,
        input  yumi_o, v_o, data_o
    );

    // The controller accepts requests and produces responses
    modport slave (
        input  v_i, w_i, addr_i, data_i, w_mask_i, yumi_i,
        output yumi_o, v_o, data_o
    );
endinterface
`default_nettype wire

// File: rtl/bsg_mem_1rw_sync_mask_write_var_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_mem_1rw_sync_mask_write_var_ctrl
//  Purpose  : Zero-fills a single-port masked-write synchronous-read memory
//             after reset, then round-robin arbitrates two requesters onto
//             it and returns read data through per-requester response
//             registers with a valid/yumi handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module bsg_mem_1rw_sync_mask_write_var_ctrl #(
    parameter int width_p      = 32,
    parameter int mask_width_p = 8,
    parameter int els_p        = 8,
    parameter int addr_width_lp = (els_p == 1) ? 1 : $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    bsg_mem_1rw_sync_mask_write_var_ctrl_if.slave client,

    output logic                     mem_v_o,
    output logic                     mem_w_o,
    output logic [addr_width_lp-1:0] mem_addr_o,
    output logic [width_p-1:0]       mem_data_o,
    output logic [width_p-1:0]       mem_w_mask_o,
    input  logic [width_p-1:0]       mem_data_i
);

    localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

    // Mask chunks must tile the data word exactly
    if (width_p % mask_width_p != 0) begin : g_bad_mask_width
        $error("width_p must be a multiple of mask_width_p");
    end

    typedef enum logic [0:0] {
        eInit = 1'b0,
        eRun  = 1'b1
    } state_e;

    state_e                    state_q, state_d;
    logic [addr_width_lp-1:0]  cnt_q, cnt_d;
    logic [1:0]                pending_q, pending_d;
    logic [1:0]                v_q, v_d;
    logic [1:0][width_p-1:0]   data_q, data_d;
    logic                      last_q, last_d;    // last granted requester
    logic [1:0]                yumi;
    logic [1:0]                elig;
    logic                      grant_v;
    logic                      grant_id;

    assign client.yumi_o = yumi;
    assign client.v_o    = v_q;
    assign client.data_o = data_q;

    // State register; last_q resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= eInit;
            cnt_q     <= '0;
            pending_q <= '0;
            v_q       <= '0;
            data_q    <= '0;
            last_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            v_q       <= v_d;
            data_q    <= data_d;
            last_q    <= last_d;
        end
    end

    // Next state, arbitration, memory drive and response capture
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pending_d    = '0;
        v_d          = v_q;
        data_d       = data_q;
        last_d       = last_q;
        yumi         = '0;
        elig         = '0;
        grant_v      = 1'b0;
        grant_id     = 1'b0;
        mem_v_o      = 1'b0;
        mem_w_o      = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        mem_w_mask_o = '0;

        // A read granted last cycle has its data on mem_data_i now; a load
        // landing on the same edge as a yumi keeps the response valid.
        for (int r = 0; r < 2; r++) begin
            if (pending_q[r]) begin
                v_d[r]    = 1'b1;
                data_d[r] = mem_data_i;
            end else if (client.yumi_i[r]) begin
                v_d[r]    = 1'b0;
            end
        end

        case (state_q)
            eInit: begin
                mem_v_o      = 1'b1;
                mem_w_o      = 1'b1;
                mem_addr_o   = cnt_q;
                mem_w_mask_o = '1;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == last_addr_lp) begin
                    state_d = eRun;
                end
            end
            eRun: begin
                // Writes never touch the response path; reads need a free
                // response slot (empty, or being consumed this cycle).
                for (int r = 0; r < 2; r++) begin
                    elig[r] = client.v_i[r] &
                              (client.w_i[r] |
                               (~pending_q[r] & (~v_q[r] | client.yumi_i[r])));
                end
                grant_v  = |elig;
                grant_id = (&elig) ? ~last_q : elig[1];
                if (grant_v) begin
                    yumi[grant_id] = 1'b1;
                    last_d         = grant_id;
                    mem_v_o        = 1'b1;
                    mem_w_o        = client.w_i[grant_id];
                    mem_addr_o     = client.addr_i[grant_id];
                    mem_data_o     = client.data_i[grant_id];
                    if (client.w_i[grant_id]) begin
                        mem_w_mask_o = client.w_mask_i[grant_id];
                    end else begin
                        pending_d[grant_id] = 1'b1;
                    end
                end
            end
            default: begin
                state_d = eInit;
            end
        endcase
    end

`ifndef SYNTHESIS
    // A response may only be consumed while it is valid
    assert property (@(posedge clk_i) disable iff (reset_i) ((client.yumi_i & ~v_q) == 2'b00))
        else $error("yumi_i asserted without v_o");
`endif

endmodule
`default_nettype wire
